dev_bridge: RTL and testbench

DEV_BRIDGE -- requirements
Module: dev_bridge

---
 rtl/bridge_pkg.sv | 28 ++
 rtl/dev_decode.sv | 26 ++
 rtl/dev_bridge.sv | 132 +++++++++++++
 tb/tb_dev_bridge.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-timer bridge: FSM states, default device
// windows, timer register offsets and the window-hit helper.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [31:0] DEV0_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE_DEF = 32'h0000_7F10;
    localparam logic [31:0] WIN_BYTES     = 32'd12;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int unsigned HWINT_W = 6;

    // Addresses below base wrap to a huge offset, so one unsigned compare covers both bounds.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return (off < WIN_BYTES) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dev_decode.sv
// Combinational address decode for the two timer windows; word-aligned hits
// only, anything else reports an error.
module dev_decode
    import bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
    parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF
) (
    input  logic [31:0] addr_i,
    output logic        sel0_o,
    output logic        sel1_o,
    output logic        err_o
);

    logic hit0;
    logic hit1;

    always_comb begin
        hit0   = in_window(addr_i, DEV0_BASE);
        hit1   = in_window(addr_i, DEV1_BASE);
        sel0_o = hit0;
        sel1_o = hit1 & ~hit0;
        err_o  = ~(hit0 | hit1);
    end

endmodule

// File: rtl/dev_bridge.sv
// CPU request/acknowledge bridge onto two timer register windows, plus a
// registered interrupt vector. Fixed 3-cycle mapped access, 2-cycle error.
module dev_bridge
    import bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
    parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 PR_REQ,
    input  logic [31:0]          PR_ADDR,
    input  logic                 PR_WE,
    input  logic [31:0]          PR_WD,
    output logic [31:0]          PR_RD,
    output logic                 PR_ACK,
    output logic                 PR_ERR,
    output logic [HWINT_W-1:0]   HWINT,
    output logic [3:2]           ADD_O,
    output logic [31:0]          DAT_O,
    output logic                 WE0_O,
    output logic                 WE1_O,
    input  logic [31:0]          DAT0_I,
    input  logic [31:0]          DAT1_I,
    input  logic                 IRQ0_I,
    input  logic                 IRQ1_I
);

    state_e             state_q;
    logic [31:0]        rd_q;
    logic [31:0]        rd_d;
    logic               ack_q;
    logic               err_q;
    logic [HWINT_W-1:0] hwint_q;
    logic [HWINT_W-1:0] hwint_d;
    logic [1:0]         add_q;
    logic [31:0]        dat_q;
    logic               we0_q;
    logic               we1_q;
    logic               wr_q;
    logic               dev1_q;

    logic               sel0;
    logic               sel1;
    logic               dec_err;

    dev_decode #(
        .DEV0_BASE (DEV0_BASE),
        .DEV1_BASE (DEV1_BASE)
    ) u_decode (
        .addr_i (PR_ADDR),
        .sel0_o (sel0),
        .sel1_o (sel1),
        .err_o  (dec_err)
    );

    always_comb begin
        rd_d    = wr_q ? '0 : (dev1_q ? DAT1_I : DAT0_I);
        hwint_d = '0;
        hwint_d[0] = IRQ0_I;
        hwint_d[1] = IRQ1_I;
    end

    // Device-side outputs are loaded on entry to ACCESS so they are valid for
    // exactly that cycle; the read data is captured on the edge that leaves it.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            hwint_q <= '0;
            add_q   <= '0;
            dat_q   <= '0;
            we0_q   <= 1'b0;
            we1_q   <= 1'b0;
            wr_q    <= 1'b0;
            dev1_q  <= 1'b0;
        end else begin
            hwint_q <= hwint_d;
            we0_q   <= 1'b0;
            we1_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (PR_REQ) begin
                        if (dec_err) begin
                            state_q <= ST_RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rd_q    <= '0;
                        end else begin
                            state_q <= ST_ACCESS;
                            add_q   <= PR_ADDR[3:2];
                            dat_q   <= PR_WD;
                            wr_q    <= PR_WE;
                            dev1_q  <= sel1;
                            we0_q   <= PR_WE & sel0;
                            we1_q   <= PR_WE & sel1;
                        end
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_RESP;
                    ack_q   <= 1'b1;
                    rd_q    <= rd_d;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign PR_RD  = rd_q;
    assign PR_ACK = ack_q;
    assign PR_ERR = err_q;
    assign HWINT  = hwint_q;
    assign ADD_O  = add_q;
    assign DAT_O  = dat_q;
    assign WE0_O  = we0_q;
    assign WE1_O  = we1_q;

    a_we_exclusive: assert property (@(posedge CLK_I) !(WE0_O && WE1_O));
    a_we_in_access: assert property (@(posedge CLK_I) (WE0_O || WE1_O) |-> (state_q == ST_ACCESS));
    a_add_in_range: assert property (@(posedge CLK_I) (state_q == ST_ACCESS) |-> (ADD_O <= REG_COUNT));

endmodule

// File: tb/tb_dev_bridge.sv
// Bench for dev_bridge: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_dev_bridge;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        PR_REQ;
    logic [31:0] PR_ADDR;
    logic        PR_WE;
    logic [31:0] PR_WD;
    logic [31:0] PR_RD;
    logic        PR_ACK;
    logic        PR_ERR;
    logic [5:0]  HWINT;
    logic [1:0]  ADD_O;
    logic [31:0] DAT_O;
    logic        WE0_O;
    logic        WE1_O;
    logic [31:0] DAT0_I;
    logic [31:0] DAT1_I;
    logic        IRQ0_I;
    logic        IRQ1_I;

    dev_bridge dut (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .PR_REQ  (PR_REQ),
        .PR_ADDR (PR_ADDR),
        .PR_WE   (PR_WE),
        .PR_WD   (PR_WD),
        .PR_RD   (PR_RD),
        .PR_ACK  (PR_ACK),
        .PR_ERR  (PR_ERR),
        .HWINT   (HWINT),
        .ADD_O   (ADD_O),
        .DAT_O   (DAT_O),
        .WE0_O   (WE0_O),
        .WE1_O   (WE1_O),
        .DAT0_I  (DAT0_I),
        .DAT1_I  (DAT1_I),
        .IRQ0_I  (IRQ0_I),
        .IRQ1_I  (IRQ1_I)
    );

    always #5 CLK_I = ~CLK_I;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: -1 = unmapped, else device index.
    function automatic int decode(input logic [31:0] a);
        longint x;
        x = longint'(a);
        if (x % 4 != 0) return -1;
        if (x >= 64'h7F00 && x < 64'h7F00 + 12) return 0;
        if (x >= 64'h7F10 && x < 64'h7F10 + 12) return 1;
        return -1;
    endfunction

    int          k = 0;
    int          next_accept = 0;
    int          acc_edge = -1;
    int          rsp_edge = -1;
    bit          m_started = 0;
    bit          rst_cyc = 0;
    bit          acc_we;
    int          acc_dev;
    logic [1:0]  acc_add;
    logic [31:0] acc_dat;
    logic [31:0] rsp_rd;
    bit          rsp_err;
    logic [5:0]  exp_hw;

    always @(posedge CLK_I) begin
        int d;
        longint base;
        k++;
        if (RST_I) begin
            m_started   = 1;
            rst_cyc     = 1;
            acc_edge    = -1;
            rsp_edge    = -1;
            next_accept = k + 1;
            exp_hw      = '0;
        end else begin
            rst_cyc = 0;
            exp_hw  = {4'b0000, IRQ1_I, IRQ0_I};
            if (acc_edge == k - 1) begin
                rsp_edge = k;
                rsp_err  = 0;
                rsp_rd   = acc_we ? 32'h0 : (acc_dev == 1 ? DAT1_I : DAT0_I);
            end
            if (PR_REQ && k >= next_accept) begin
                d = decode(PR_ADDR);
                if (d < 0) begin
                    rsp_edge    = k;
                    rsp_err     = 1;
                    rsp_rd      = 32'h0;
                    next_accept = k + 2;
                end else begin
                    base        = (d == 0) ? 64'h7F00 : 64'h7F10;
                    acc_edge    = k;
                    acc_dev     = d;
                    acc_we      = PR_WE;
                    acc_add     = 2'((longint'(PR_ADDR) - base) / 4);
                    acc_dat     = PR_WD;
                    next_accept = k + 3;
                end
            end
        end
    end

    always @(negedge CLK_I) begin
        if (m_started) begin
            if (rst_cyc) begin
                chk("model_reset_outs",
                    {PR_RD, PR_ACK, PR_ERR, HWINT, ADD_O, DAT_O, WE0_O, WE1_O}, '0);
            end else begin
                chk("model_we0", WE0_O, (acc_edge == k) && acc_we && (acc_dev == 0));
                chk("model_we1", WE1_O, (acc_edge == k) && acc_we && (acc_dev == 1));
                if (acc_edge == k) begin
                    chk("model_add", ADD_O, acc_add);
                    chk("model_dat", DAT_O, acc_dat);
                end
                chk("model_ack", PR_ACK, rsp_edge == k);
                if (rsp_edge == k) begin
                    chk("model_err", PR_ERR, rsp_err);
                    chk("model_rd", PR_RD, rsp_rd);
                end
                chk("model_hwint", HWINT, exp_hw);
            end
        end
    end

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK_I);
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d);
        PR_REQ  = 1'b1;
        PR_ADDR = a;
        PR_WE   = w;
        PR_WD   = d;
    endtask

    // Scramble the bus after the request is latched; the in-flight access must not care.
    task automatic drop();
        PR_REQ  = 1'b0;
        PR_ADDR = $urandom;
        PR_WD   = $urandom;
        PR_WE   = 1'($urandom);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] err_addrs [3];
        logic [31:0] bnd_addrs [5];
        logic        bnd_we    [5];
        int          acks;
        int          first_s;
        int          last_s;
        bit          spacing_ok;

        RST_I   = 1'b1;
        PR_REQ  = 1'b0;
        PR_ADDR = '0;
        PR_WE   = 1'b0;
        PR_WD   = '0;
        DAT0_I  = 32'h1111_0000;
        DAT1_I  = 32'h2222_0000;
        IRQ0_I  = 1'b0;
        IRQ1_I  = 1'b0;

        step();
        step();
        mid();
        chk("rst_ack", PR_ACK, 1'b0);
        chk("rst_hwint", HWINT, 6'h00);
        chk("rst_dat", DAT_O, 32'h0);
        chk("rst_rd", PR_RD, 32'h0);
        step();
        RST_I = 1'b0;
        step();

        // Write timer 0 PRESET.
        req(32'h0000_7F04, 1'b1, 32'h0000_0100);
        step();
        drop();
        mid();
        chk("wr_we0", WE0_O, 1'b1);
        chk("wr_we1", WE1_O, 1'b0);
        chk("wr_add", ADD_O, 2'd1);
        chk("wr_dat", DAT_O, 32'h0000_0100);
        chk("wr_ack_early", PR_ACK, 1'b0);
        step();
        mid();
        chk("wr_ack", PR_ACK, 1'b1);
        chk("wr_err", PR_ERR, 1'b0);
        chk("wr_rd", PR_RD, 32'h0);
        chk("wr_we0_off", WE0_O, 1'b0);
        step();

        // Read timer 1 COUNT.
        DAT1_I = 32'h0000_00AB;
        DAT0_I = 32'h5555_0000;
        req(32'h0000_7F18, 1'b0, 32'hFFFF_FFFF);
        step();
        drop();
        mid();
        chk("rd_add", ADD_O, 2'd2);
        chk("rd_no_strobe", {WE0_O, WE1_O}, 2'b00);
        step();
        mid();
        chk("rd_ack", PR_ACK, 1'b1);
        chk("rd_data", PR_RD, 32'h0000_00AB);
        chk("rd_err", PR_ERR, 1'b0);
        step();

        // Unmapped: hole at 0xC, misaligned, far away.
        err_addrs[0] = 32'h0000_7F0C;
        err_addrs[1] = 32'h0000_7F06;
        err_addrs[2] = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            req(err_addrs[i], 1'(i % 2 == 0), 32'hA5A5_A5A5);
            step();
            drop();
            mid();
            chk("err_ack", PR_ACK, 1'b1);
            chk("err_flag", PR_ERR, 1'b1);
            chk("err_rd", PR_RD, 32'h0);
            chk("err_no_strobe", {WE0_O, WE1_O}, 2'b00);
            step();
        end

        // Window edges, checked by the model.
        bnd_addrs[0] = 32'h0000_7F08; bnd_we[0] = 1'b0;
        bnd_addrs[1] = 32'h0000_7F10; bnd_we[1] = 1'b1;
        bnd_addrs[2] = 32'h0000_7F1C; bnd_we[2] = 1'b0;
        bnd_addrs[3] = 32'h0000_7EFC; bnd_we[3] = 1'b1;
        bnd_addrs[4] = 32'h0000_7F14; bnd_we[4] = 1'b0;
        DAT0_I = 32'h0D0D_0008;
        DAT1_I = 32'h1D1D_0014;
        for (int i = 0; i < 5; i++) begin
            req(bnd_addrs[i], bnd_we[i], 32'h1000_0000 + 32'(i));
            step();
            drop();
            repeat (3) step();
        end

        // Held request: one access every three cycles.
        acks       = 0;
        first_s    = -1;
        last_s     = -100;
        spacing_ok = 1'b1;
        DAT0_I     = 32'h0000_0C7C;
        req(32'h0000_7F00, 1'b0, 32'h0);
        for (int s = 1; s <= 12; s++) begin
            step();
            if (s == 9) drop();
            mid();
            if (PR_ACK) begin
                if (acks == 0) first_s = s;
                else if (s - last_s != 3) spacing_ok = 1'b0;
                acks++;
                last_s = s;
            end
        end
        chk("burst_acks", 32'(acks), 32'd3);
        chk("burst_spacing", spacing_ok, 1'b1);
        chk("burst_first", 32'(first_s), 32'd2);
        step();

        // Held unmapped request: model sees one error every two cycles.
        req(32'h0000_7F0C, 1'b1, 32'h0);
        repeat (5) step();
        drop();
        repeat (2) step();

        // Reset during ACCESS of a write.
        req(32'h0000_7F14, 1'b1, 32'h0000_DEAD);
        step();
        drop();
        RST_I = 1'b1;
        mid();
        chk("abort_we1_live", WE1_O, 1'b1);
        step();
        RST_I = 1'b0;
        mid();
        chk("abort_outs_zero",
            {PR_RD, PR_ACK, PR_ERR, HWINT, ADD_O, DAT_O, WE0_O, WE1_O}, '0);
        step();
        mid();
        chk("abort_no_ack", PR_ACK, 1'b0);
        DAT0_I = 32'hC0DE_0008;
        req(32'h0000_7F08, 1'b0, 32'h0);
        step();
        drop();
        mid();
        chk("post_abort_add", ADD_O, 2'd2);
        step();
        mid();
        chk("post_abort_ack", PR_ACK, 1'b1);
        chk("post_abort_rd", PR_RD, 32'hC0DE_0008);
        step();

        // Interrupts track inputs one cycle late, regardless of bus traffic.
        IRQ1_I = 1'b1;
        req(32'h0000_7F10, 1'b1, 32'h0000_0055);
        step();
        drop();
        mid();
        chk("irq1_rise", HWINT, 6'b000010);
        IRQ1_I = 1'b0;
        step();
        mid();
        chk("irq1_fall", HWINT, 6'b000000);
        chk("irq_traffic_ack", PR_ACK, 1'b1);
        IRQ0_I = 1'b1;
        step();
        mid();
        chk("irq0_rise", HWINT, 6'b000001);
        IRQ0_I = 1'b0;
        step();
        mid();
        chk("irq0_fall", HWINT, 6'b000000);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
